// File: rtl/fft_bfly_sequencer.sv
// Radix-2 FFT butterfly issue sequencer: walks every (stage, pair) once, delay-matches write-back.
// Optional twiddle index outputs are built when SEQ_TWIDDLE_EN is defined.
module fft_bfly_sequencer #(
    parameter int unsigned N          = 1024,
    parameter int unsigned BF_LATENCY = 4,
    localparam int unsigned LOGN      = $clog2(N),
    localparam int unsigned PW        = LOGN - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            issue_valid,
    output logic [LOGN-1:0] stage,
    output logic [PW-1:0]   pair_id,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_stage,
    output logic [PW-1:0]   wr_pair_id
`ifdef SEQ_TWIDDLE_EN
    ,
    output logic [PW-1:0]   tw_idx,
    output logic            tw_valid
`endif
);

    localparam int unsigned     LAT        = BF_LATENCY;
    localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);
    localparam logic [PW-1:0]   PAIR_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic            v;
        logic [LOGN-1:0] s;
        logic [PW-1:0]   p;
    } wb_t;

    state_t state;
    wb_t    pipe [LAT];
    logic   pipe_pending;

`ifdef SEQ_TWIDDLE_EN
    localparam logic [PW-1:0] PAIR_ONES = '1;

    // Twiddle index keeps only the top 'stage' bits of the pair index.
    function automatic logic [PW-1:0] tw_of(input logic [LOGN-1:0] s, input logic [PW-1:0] p);
        logic [LOGN-1:0] sh;
        sh = LOGN'(PW) - s;
        return p & (PAIR_ONES << sh);
    endfunction

    assign tw_valid = issue_valid;
`endif

    // A pair still in flight anywhere except the final (currently writing) slot blocks the next stage.
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i + 1 < int'(LAT); i++) begin
            pipe_pending = pipe_pending | pipe[i].v;
        end
    end

    // Write-back delay line; free-running so stall never skews write timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {issue_valid, stage, pair_id};
            for (int i = 1; i < int'(LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign wr_en      = pipe[LAT-1].v;
    assign wr_stage   = pipe[LAT-1].s;
    assign wr_pair_id = pipe[LAT-1].p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            stage       <= '0;
            pair_id     <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SEQ_TWIDDLE_EN
            tw_idx      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        stage       <= '0;
                        pair_id     <= '0;
                        issue_valid <= 1'b1;
                        busy        <= 1'b1;
`ifdef SEQ_TWIDDLE_EN
                        tw_idx      <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (issue_valid && pair_id == PAIR_LAST) begin
                        state       <= S_DRAIN;
                        pair_id     <= '0;
                        issue_valid <= 1'b0;
`ifdef SEQ_TWIDDLE_EN
                        tw_idx      <= '0;
`endif
                    end else begin
                        // The pair shown this cycle is consumed; stall only gates the next one.
                        if (issue_valid) begin
                            pair_id <= pair_id + 1'b1;
`ifdef SEQ_TWIDDLE_EN
                            tw_idx  <= tw_of(stage, PW'(pair_id + 1'b1));
`endif
                        end
                        issue_valid <= ~stall;
                    end
                end
                S_DRAIN: begin
                    if (!pipe_pending) begin
                        if (stage == STAGE_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_ISSUE;
                            stage       <= stage + 1'b1;
                            issue_valid <= 1'b1;
`ifdef SEQ_TWIDDLE_EN
                            tw_idx      <= '0;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Scoreboard bench for fft_bfly_sequencer: small instance with random stall/start/reset,
// large instance checked for full unstalled ordering and timing.
module tb_fft_bfly_sequencer;

    localparam int N     = 8;
    localparam int L     = 2;
    localparam int LOGN  = 3;
    localparam int PW    = 2;
    localparam int NP    = N / 2;
    localparam int BN    = 1024;
    localparam int BL    = 4;
    localparam int BLOGN = 10;
    localparam int BPW   = 9;
    localparam int BNP   = BN / 2;

    logic            clk;
    logic            rst, start, stall;
    logic            busy, done, issue_valid, wr_en;
    logic [LOGN-1:0] stage, wr_stage;
    logic [PW-1:0]   pair_id, wr_pair_id;

    logic             rst_big, start_big;
    logic             b_busy, b_done, b_iv, b_wr;
    logic [BLOGN-1:0] b_stage, b_wr_stage;
    logic [BPW-1:0]   b_pair, b_wr_pair;

`ifdef SEQ_TWIDDLE_EN
    logic [PW-1:0]  tw_idx;
    logic           tw_valid;
    logic [BPW-1:0] b_tw_idx;
    logic           b_tw_valid;
`endif

    fft_bfly_sequencer #(.N(N), .BF_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .issue_valid(issue_valid),
        .stage(stage), .pair_id(pair_id),
        .wr_en(wr_en), .wr_stage(wr_stage), .wr_pair_id(wr_pair_id)
`ifdef SEQ_TWIDDLE_EN
        , .tw_idx(tw_idx), .tw_valid(tw_valid)
`endif
    );

    fft_bfly_sequencer #(.N(BN), .BF_LATENCY(BL)) dut_big (
        .clk(clk), .rst(rst_big), .start(start_big), .stall(1'b0),
        .busy(b_busy), .done(b_done), .issue_valid(b_iv),
        .stage(b_stage), .pair_id(b_pair),
        .wr_en(b_wr), .wr_stage(b_wr_stage), .wr_pair_id(b_wr_pair)
`ifdef SEQ_TWIDDLE_EN
        , .tw_idx(b_tw_idx), .tw_valid(b_tw_valid)
`endif
    );

    typedef struct {
        int cyc;
        int s;
        int p;
        int tw;
    } ev_t;

    ev_t exp_iss[$];
    ev_t exp_wr[$];
    int  exp_done[$];
    bit  stall_pat [256];

    int cyc          = 0;
    int n_checks     = 0;
    int n_fail       = 0;
    int busy_lo      = 1;
    int busy_hi      = 0;
    int bt0          = 0;
    int b_iss_n      = 0;
    int b_wr_n       = 0;
    int b_done_n     = 0;
    bit big_finished = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic bit outs_zero();
        bit z;
        z = ({busy, done, issue_valid, stage, pair_id, wr_en, wr_stage, wr_pair_id} == '0);
`ifdef SEQ_TWIDDLE_EN
        z = z && ({tw_idx, tw_valid} == '0);
`endif
        return z;
    endfunction

    // Reference schedule: pair 0 of each stage issues one cycle after entry, later pairs wait
    // out stall cycles, and the next stage (or done) comes L+1 cycles after a stage's last issue.
    task automatic model_run(input int t0, output int done_c);
        int  c;
        ev_t e;
        c = 1;
        for (int s = 0; s < LOGN; s++) begin
            for (int p = 0; p < NP; p++) begin
                if (p > 0) begin
                    c++;
                    while (stall_pat[c-1]) c++;
                end
                e.cyc = t0 + c;
                e.s   = s;
                e.p   = p;
                e.tw  = (p >> (PW - s)) << (PW - s);
                exp_iss.push_back(e);
                e.cyc = t0 + c + L;
                exp_wr.push_back(e);
            end
            c = c + L + 1;
        end
        done_c = t0 + c;
        exp_done.push_back(done_c);
    endtask

    task automatic apply_reset();
        #1 rst = 1'b1;
        #1;
        check(outs_zero(), "async_reset",
              $sformatf("busy=%0b iv=%0b wr=%0b stage=%0d, all want 0", busy, issue_valid, wr_en, stage));
        exp_iss.delete();
        exp_wr.delete();
        exp_done.delete();
        busy_lo = 1;
        busy_hi = 0;
        start   = 1'b0;
        stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_transform(input int pct, input bit directed, input bit poke, input int abort_rel);
        int t0;
        int dc;
        for (int k = 0; k < 256; k++) begin
            stall_pat[k] = directed ? (k == 1 || k == 2) : ($urandom_range(0, 99) < pct);
        end
        t0 = cyc;
        model_run(t0, dc);
        busy_lo = t0 + 1;
        busy_hi = dc - 1;
        start   = 1'b1;
        stall   = stall_pat[0];
        for (int k = 1; t0 + k <= dc + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_rel) begin
                apply_reset();
                return;
            end
            stall = stall_pat[k];
            start = (poke && t0 + k <= dc) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        stall = 1'b0;
        check(exp_iss.size() == 0 && exp_wr.size() == 0 && exp_done.size() == 0, "run_drained",
              $sformatf("left iss=%0d wr=%0d done=%0d, want 0", exp_iss.size(), exp_wr.size(), exp_done.size()));
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        int  d;
        if (!rst) begin
            while (exp_iss.size() != 0 && exp_iss[0].cyc < cyc) begin
                e = exp_iss.pop_front();
                check(1'b0, "issue_missing", $sformatf("(%0d,%0d) due c%0d not seen", e.s, e.p, e.cyc));
            end
            while (exp_wr.size() != 0 && exp_wr[0].cyc < cyc) begin
                e = exp_wr.pop_front();
                check(1'b0, "wr_missing", $sformatf("(%0d,%0d) due c%0d not seen", e.s, e.p, e.cyc));
            end
            while (exp_done.size() != 0 && exp_done[0] < cyc) begin
                d = exp_done.pop_front();
                check(1'b0, "done_missing", $sformatf("done due c%0d not seen", d));
            end
            if (issue_valid) begin
                if (exp_iss.size() == 0) begin
                    check(1'b0, "issue_unexpected", $sformatf("c%0d got (%0d,%0d), want none", cyc, stage, pair_id));
                end else begin
                    e = exp_iss.pop_front();
                    check(cyc == e.cyc && int'(stage) == e.s && int'(pair_id) == e.p, "issue",
                          $sformatf("got c%0d (%0d,%0d) want c%0d (%0d,%0d)", cyc, stage, pair_id, e.cyc, e.s, e.p));
`ifdef SEQ_TWIDDLE_EN
                    check(int'(tw_idx) == e.tw, "twiddle",
                          $sformatf("(%0d,%0d) got tw=%0d want %0d", e.s, e.p, tw_idx, e.tw));
`endif
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check(1'b0, "wr_unexpected", $sformatf("c%0d got (%0d,%0d), want none", cyc, wr_stage, wr_pair_id));
                end else begin
                    e = exp_wr.pop_front();
                    check(cyc == e.cyc && int'(wr_stage) == e.s && int'(wr_pair_id) == e.p, "wr",
                          $sformatf("got c%0d (%0d,%0d) want c%0d (%0d,%0d)", cyc, wr_stage, wr_pair_id, e.cyc, e.s, e.p));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check(1'b0, "done_unexpected", $sformatf("c%0d got done, want none", cyc));
                end else begin
                    d = exp_done.pop_front();
                    check(cyc == d, "done", $sformatf("got c%0d want c%0d", cyc, d));
                end
            end
            check(busy == (cyc >= busy_lo && cyc <= busy_hi), "busy",
                  $sformatf("c%0d got %0b want window %0d..%0d", cyc, busy, busy_lo, busy_hi));
`ifdef SEQ_TWIDDLE_EN
            check(tw_valid == issue_valid, "tw_valid", $sformatf("got %0b want %0b", tw_valid, issue_valid));
`endif
        end
    end

    always @(negedge clk) begin : big_mon
        int es, ep, ec;
        if (!rst_big) begin
            if (b_iv) begin
                es = b_iss_n / BNP;
                ep = b_iss_n % BNP;
                ec = bt0 + 1 + es * (BNP + BL) + ep;
                check(cyc == ec && int'(b_stage) == es && int'(b_pair) == ep, "big_issue",
                      $sformatf("n=%0d got c%0d (%0d,%0d) want c%0d (%0d,%0d)", b_iss_n, cyc, b_stage, b_pair, ec, es, ep));
`ifdef SEQ_TWIDDLE_EN
                check(b_tw_valid && int'(b_tw_idx) == ((ep >> (BPW - es)) << (BPW - es)), "big_twiddle",
                      $sformatf("(%0d,%0d) got tw=%0d", es, ep, b_tw_idx));
`endif
                b_iss_n++;
            end
            if (b_wr) begin
                es = b_wr_n / BNP;
                ep = b_wr_n % BNP;
                ec = bt0 + 1 + es * (BNP + BL) + ep + BL;
                check(cyc == ec && int'(b_wr_stage) == es && int'(b_wr_pair) == ep, "big_wr",
                      $sformatf("n=%0d got c%0d (%0d,%0d) want c%0d (%0d,%0d)", b_wr_n, cyc, b_wr_stage, b_wr_pair, ec, es, ep));
                b_wr_n++;
            end
            if (b_done) begin
                check(cyc == bt0 + BLOGN * (BNP + BL) + 1 && b_busy == 1'b0, "big_done",
                      $sformatf("got c%0d busy=%0b want c%0d busy=0", cyc, b_busy, bt0 + BLOGN * (BNP + BL) + 1));
                b_done_n++;
            end
        end
    end

    initial begin : big_drv
        rst_big   = 1'b1;
        start_big = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_big = 1'b0;
        @(posedge clk);
        #1;
        bt0       = cyc;
        start_big = 1'b1;
        @(posedge clk);
        #1 start_big = 1'b0;
        while (cyc <= bt0 + BLOGN * (BNP + BL) + 6) @(posedge clk);
        #1;
        check(b_iss_n == BLOGN * BNP && b_wr_n == BLOGN * BNP && b_done_n == 1, "big_counts",
              $sformatf("iss=%0d wr=%0d done=%0d want %0d %0d 1", b_iss_n, b_wr_n, b_done_n, BLOGN * BNP, BLOGN * BNP));
        big_finished = 1'b1;
    end

    initial begin : main_drv
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(outs_zero(), "reset_state",
              $sformatf("busy=%0b iv=%0b wr=%0b done=%0b, all want 0", busy, issue_valid, wr_en, done));
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_transform(0, 1'b0, 1'b0, -1);
        run_transform(0, 1'b1, 1'b0, -1);
        run_transform(0, 1'b0, 1'b1, -1);
        run_transform(0, 1'b0, 1'b0, 11);
        run_transform(0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run_transform(30, 1'b0, 1'b1, -1);
        end
        wait (big_finished);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
